rom_addr_sequencer: RTL
=======================

Name: rom_addr_sequencer

Overview:
Control stage directly upstream and downstream of the 8x16 block ROM on the board demo path. It debounces the raw push-buttons and steps a ROM address up or down, either manually or in auto-scan mode. It waits out the ROM's registered read latency, then captures the ROM word into a hold register that drives the 7-segment display driver's 16-bit input. This replaces driving the ROM address straight from the raw buttons.

Parameters:
ADDR_W, 3, ROM address width; depth = 2**ADDR_W
DATA_W, 16, ROM word width
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a button level change (20 ms at 50 MHz)
SCAN_DIV, 50000000, clk cycles between auto-scan steps
RD_LAT, 1, ROM read latency in clk cycles (registered douta)

Ports:
clk  in  1  system clock (mclk domain), rising edge
clr  in  1  reset, synchronous, active-high
btn  in  3  raw asynchronous buttons: [0] up, [1] down, [2] mode toggle
rom_data  in  DATA_W  ROM douta
rom_addr  out  ADDR_W  ROM addra, registered
disp_data  out  DATA_W  captured word to display driver, registered
data_valid  out  1  one-cycle pulse when disp_data loads
auto_mode  out  1  1 = auto-scan active (LED)
busy  out  1  1 while a fetch is in flight

Behaviour:
- Reset (clr=1 at a rising edge): rom_addr=0, disp_data=0, data_valid=0, auto_mode=0, scan counter=0, debounced levels=0, pending=none, state=FETCH with latency counter=0, so address 0 is fetched automatically after reset. busy=1.
- Input path, per button: 2-flop synchronizer, then debounce. A per-button counter increments while the synced level differs from the debounced level. It clears when the levels match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. A 0->1 transition of a debounced level produces a one-cycle press pulse.
- Mode: a press on btn[2] toggles auto_mode in any state. The scan counter clears on every toggle.
- Step requests:
  - Manual mode: up press = +1, down press = -1. Up and down pressed in the same cycle = no request.
  - Auto mode: up/down presses are ignored. When the scan counter reaches SCAN_DIV-1, it wraps to 0 and issues a +1 request.
- Arithmetic is modulo 2**ADDR_W. Up at max address gives 0; down at 0 gives max.
- FSM states: IDLE, FETCH, CAPTURE.
  - IDLE: busy=0. On a request, or a pending request, rom_addr <= rom_addr±1 and state goes to FETCH. The latency counter is 0 on entry.
  - FETCH: busy=1. Stays RD_LAT cycles, then goes to CAPTURE.
  - CAPTURE: busy=1. On the edge leaving CAPTURE, disp_data <= rom_data, data_valid=1 for exactly that following cycle, and state goes to IDLE.
  - Net latency: disp_data loads on the (RD_LAT+1)th rising edge after the edge that updated rom_addr.
- Requests while busy: one pending slot holds a direction. A later request overwrites it (last wins). An up and a down pending in the same cycle clear the slot. Leaving auto mode clears a pending auto step. The pending request is served in the IDLE cycle immediately after CAPTURE.
- rom_addr is stable throughout FETCH and CAPTURE.
- Reset mid-fetch: the reset values above apply. Any in-flight or pending request is discarded, and the fetch of address 0 restarts.
- disp_data holds its value between captures. data_valid never asserts for two consecutive cycles.

Test Plan:
- Reset release, ROM model: data = 16'hA000 + addr, RD_LAT=1. Required: rom_addr=0, disp_data=16'hA000, data_valid pulse on the 2nd edge after clr falls, busy then 0.
- DEBOUNCE_CYCLES=4. btn[0] bouncing (1,0,1,0), then held 1 for 10 cycles. Required: exactly one increment, rom_addr=1, disp_data=16'hA001 one data_valid later. Release bounce produces no step.
- Seven up presses from address 7. Required: first press wraps to 0 (disp_data=16'hA000). A down press at 0 gives 7 (16'hA007).
- Two up presses 1 cycle apart, second while busy. Required: rom_addr goes 0->1->2, two data_valid pulses, final disp_data=16'hA002. Up and down pulsed in the same cycle gives no change.
- SCAN_DIV=8, toggle auto mode. Required: +1 step every 8 cycles, addresses 1,2,...,7,0. Manual up presses are ignored. A second toggle stops scanning with auto_mode=0.
- Assert clr during FETCH of address 5. Required: all outputs return to reset values, then fetch address 0 and show disp_data=16'hA000.

Source files
------------

// File: rtl/rom_addr_sequencer_if.sv
// Bundles the button inputs, ROM read port and display-side outputs of rom_addr_sequencer.
interface rom_addr_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic [2:0]        btn;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] disp_data;
  logic              data_valid;
  logic              auto_mode;
  logic              busy;

  modport master (
    input  btn, rom_data,
    output rom_addr, disp_data, data_valid, auto_mode, busy
  );

  modport slave (
    output btn, rom_data,
    input  rom_addr, disp_data, data_valid, auto_mode, busy
  );
endinterface

// File: rtl/rom_addr_sequencer.sv
// Debounced up/down/auto stepping of a ROM address, with the ROM word captured
// after the read latency into a hold register for the 7-segment driver.
module rom_addr_sequencer #(
  parameter int ADDR_W          = 3,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 50000000,
  parameter int RD_LAT          = 1
) (
  input  logic              clk,
  input  logic              clr,
  rom_addr_sequencer_if.master bus
);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [2:0]        sync1, sync2, deb, deb_q, press;
  logic [DB_W-1:0]   db_cnt [3];
  logic [SC_W-1:0]   scan_cnt;
  logic              scan_tick, req_up, req_dn;
  logic              pend_valid, pend_up, pend_auto;
  logic [1:0]        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] disp;
  logic              dv, auto_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  // No auto tick in the cycle the mode toggles, so leaving auto never races a fresh step.
  assign scan_tick = auto_q & ~press[2] & (scan_cnt == SC_W'(SCAN_DIV - 1));
  assign req_up    = auto_q ? scan_tick : (press[0] & ~press[1]);
  assign req_dn    = ~auto_q & press[1] & ~press[0];

  always_ff @(posedge clk) begin
    if (clr) begin
      auto_q   <= 1'b0;
      scan_cnt <= '0;
    end else if (press[2]) begin
      auto_q   <= ~auto_q;
      scan_cnt <= '0;
    end else if (auto_q) begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SC_W'(1);
    end else begin
      scan_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_FETCH;
      lat_cnt    <= '0;
      addr       <= '0;
      disp       <= '0;
      dv         <= 1'b0;
      pend_valid <= 1'b0;
      pend_up    <= 1'b0;
      pend_auto  <= 1'b0;
    end else begin
      dv <= 1'b0;
      case (state)
        S_IDLE: begin
          lat_cnt <= '0;
          if (req_up || req_dn) begin
            addr       <= req_up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
            state      <= S_FETCH;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            addr       <= pend_up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
            state      <= S_FETCH;
            pend_valid <= 1'b0;
          end
        end
        S_FETCH: begin
          if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
            state   <= S_CAPTURE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        S_CAPTURE: begin
          disp  <= bus.rom_data;
          dv    <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Requests arriving mid-fetch park in a single last-wins slot.
      if (state != S_IDLE && (req_up || req_dn)) begin
        pend_valid <= 1'b1;
        pend_up    <= req_up;
        pend_auto  <= auto_q;
      end else if (press[2] && auto_q && pend_auto) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.rom_addr   = addr;
  assign bus.disp_data  = disp;
  assign bus.data_valid = dv;
  assign bus.auto_mode  = auto_q;
  assign bus.busy       = (state != S_IDLE);
endmodule
